sysid_checker: RTL

Avalon-MM read master that sits directly downstream of the system ID slave. It reads the 32-bit ID word (address 0) and the 32-bit build timestamp word (address 1) and compares both against build-time parameters. It reports pass/fail/timeout flags that gate visualizer start-up and can be shown on status LEDs. A check runs once automatically after reset, and again on each `start` pulse.

---
 rtl/sysid_checker_if.sv | 19 +
 rtl/sysid_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sysid_checker_if.sv
// Avalon-MM read channel between the sysid checker (master) and the
// system ID slave.
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sysid_checker.sv
// System ID checker: reads the ID word (addr 0) and the build timestamp
// (addr 1) from the sysid slave and compares both against the values this
// image was built with. Flags gate visualizer start-up / drive status LEDs.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID       = 32'd0,
  parameter logic [31:0] EXPECTED_TS       = 32'd1433223846,
  parameter int unsigned TIMEOUT_CYCLES    = 255,
  parameter bit          USE_READDATAVALID = 1'b0,
  parameter bit          AUTO_START        = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  sysid_checker_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   timeout,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_FINISH
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        first_q;
  logic        busy_q, done_q;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;

  // Request phase is purely a function of state, so an async reset drops
  // avm_read in the same instant it forces IDLE.
  assign bus.avm_read    = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
  assign bus.avm_address = (state_q == S_TS_REQ);

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_val_q;
  assign ts_value = ts_val_q;

  // Next-state, timeout counter and capture/flag updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    timeout_d = timeout_q;
    id_val_d  = id_val_q;
    ts_val_d  = ts_val_q;

    unique case (state_q)
      S_IDLE: begin
        // The first cycle out of reset belongs to AUTO_START; start is
        // deliberately ignored there.
        if (first_q ? AUTO_START : start) begin
          state_d   = S_ID_REQ;
          cnt_d     = '0;
          pass_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end

      S_ID_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (!bus.avm_waitrequest) begin
          if (USE_READDATAVALID) begin
            state_d = S_ID_WAIT;
          end else begin
            id_val_d = bus.avm_readdata;
            id_ok_d  = (bus.avm_readdata == EXPECTED_ID);
            state_d  = S_TS_REQ;
            cnt_d    = '0;
          end
        end else if (cnt_q >= TO_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end

      S_ID_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.avm_readdatavalid) begin
          id_val_d = bus.avm_readdata;
          id_ok_d  = (bus.avm_readdata == EXPECTED_ID);
          state_d  = S_TS_REQ;
          cnt_d    = '0;
        end else if (cnt_q >= TO_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end

      S_TS_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (!bus.avm_waitrequest) begin
          if (USE_READDATAVALID) begin
            state_d = S_TS_WAIT;
          end else begin
            ts_val_d = bus.avm_readdata;
            ts_ok_d  = (bus.avm_readdata == EXPECTED_TS);
            state_d  = S_FINISH;
          end
        end else if (cnt_q >= TO_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end

      S_TS_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.avm_readdatavalid) begin
          ts_val_d = bus.avm_readdata;
          ts_ok_d  = (bus.avm_readdata == EXPECTED_TS);
          state_d  = S_FINISH;
        end else if (cnt_q >= TO_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end

      S_FINISH: begin
        pass_d  = id_ok_q & ts_ok_q & ~timeout_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, flags and captured words.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      id_val_q  <= '0;
      ts_val_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= 1'b0;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_FINISH);
      pass_q    <= pass_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      id_val_q  <= id_val_d;
      ts_val_q  <= ts_val_d;
    end
  end

endmodule
